// File: rtl/led_pattern_if.sv
// LED pattern bundle: mode/enable controls in, LED drive and step strobe out.
interface led_pattern_if #(
    parameter int N_LED = 4
);
    logic [1:0]       mode;
    logic             en;
    logic [N_LED-1:0] leds;
    logic             tick;

    modport master (output mode, output en, input leds, input tick);
    modport slave  (input mode, input en, output leds, output tick);
endinterface

// File: rtl/led_pattern.sv
// LED pattern generator: flash/run/bounce/count, one step every STEP_CYC cycles.
// Latency: mode/en see 2 sync flops; leds/tick are registered. No backpressure.
module led_pattern #(
    parameter int N_LED    = 4,
    parameter int STEP_CYC = 25_000_000
) (
    input  logic          clk_50mhz,
    input  logic          rst_n,
    led_pattern_if.slave  bus
);
    localparam int            CW   = $clog2(STEP_CYC);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    logic [1:0]       mode_m, mode_s, mode_q;
    logic             en_m, en_s;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [N_LED-1:0] pat, pat_nx;
    logic [N_LED-1:0] leds_r;
    logic             tick_r, tick_nx;
    dir_t             dir, dir_nx;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_m <= 2'b00;
            mode_s <= 2'b00;
            mode_q <= 2'b00;
            en_m   <= 1'b0;
            en_s   <= 1'b0;
            cnt    <= '0;
            pat    <= '0;
            leds_r <= '1;
            tick_r <= 1'b0;
            dir    <= UP;
        end else begin
            mode_m <= bus.mode;
            mode_s <= mode_m;
            mode_q <= mode_s;
            en_m   <= bus.en;
            en_s   <= en_m;
            cnt    <= cnt_nx;
            pat    <= pat_nx;
            leds_r <= ~pat_nx;
            tick_r <= tick_nx;
            dir    <= dir_nx;
        end
    end

    always_comb begin
        cnt_nx  = cnt;
        pat_nx  = pat;
        dir_nx  = dir;
        tick_nx = 1'b0;
        // A mode change wins over a step landing on the same edge.
        if (mode_s != mode_q) begin
            cnt_nx = '0;
            dir_nx = UP;
            case (mode_s)
                2'b01, 2'b10: pat_nx = N_LED'(1);
                default:      pat_nx = '0;
            endcase
        end else if (en_s) begin
            if (cnt == LAST) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                case (mode_q)
                    2'b00: pat_nx = ~pat;
                    2'b01: pat_nx = {pat[N_LED-2:0], pat[N_LED-1]};
                    2'b10: begin
                        if (dir == UP) begin
                            if (pat[N_LED-1]) begin
                                dir_nx = DOWN;
                                pat_nx = pat >> 1;
                            end else begin
                                pat_nx = pat << 1;
                            end
                        end else begin
                            if (pat[0]) begin
                                dir_nx = UP;
                                pat_nx = pat << 1;
                            end else begin
                                pat_nx = pat >> 1;
                            end
                        end
                    end
                    default: pat_nx = pat + N_LED'(1);
                endcase
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    assign bus.leds = leds_r;
    assign bus.tick = tick_r;
endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 SHALL have parameter N_LED, default 4, number of LED channels; legal range is 2..16.
REQ-002 SHALL have parameter STEP_CYC, default 25_000_000, clock cycles per pattern step (500 ms at 50 MHz); legal minimum is 2.
REQ-003 SHALL have port clk_50mhz  input  1  system clock, 50 MHz, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  2  pattern select, asynchronous to the clock: 00 flash, 01 run, 10 bounce, 11 count.
REQ-006 SHALL have port en  input  1  step enable, asynchronous to the clock; high = run, low = freeze.
REQ-007 SHALL have port leds  output  N_LED  LED drive, active-low (0 = lit).
REQ-008 SHALL have port tick  output  1  one-cycle strobe, asserted on each pattern step.

Function
REQ-009 SHALL pass mode and en through a 2-flop synchroniser each; mode_s and en_s denote the second-stage outputs.
REQ-010 SHALL hold internal active-high pattern pat[N_LED-1:0] and drive leds = ~pat, registered with no combinational path from inputs.
REQ-011 SHALL hold step counter cnt, width clog2(STEP_CYC); while en_s=1, cnt increments by 1 per cycle and wraps STEP_CYC-1 -> 0.
REQ-012 SHALL assert tick for exactly the cycle following the cycle in which cnt==STEP_CYC-1 and en_s=1, so the step period is STEP_CYC cycles.
REQ-013 SHALL, while en_s=0, hold cnt, pat and dir unchanged and keep tick=0; stepping resumes from the held cnt value once en_s returns to 1.
REQ-014 SHALL register mode_q <= mode_s; when mode_s != mode_q, on that edge: cnt<=0, tick<=0, dir<=up, pat<=init(mode_s).
REQ-015 SHALL use these init values: flash 0...0; run 0...01; bounce 0...01; count 0...0.
REQ-016 SHALL, on a mode change, complete reinit on the 3rd rising edge after the mode input changes, provided setup is met.
REQ-017 SHALL give a mode change priority over a step falling in the same cycle; the step is discarded.
REQ-018 SHALL, on a step in flash mode, set pat <= ~pat (all LEDs toggle together).
REQ-019 SHALL, on a step in run mode, rotate pat left by one: bit N_LED-1 -> bit 0.
REQ-020 SHALL, on a step in bounce mode with dir=up: if pat[N_LED-1]=1 then dir<=down and pat<=pat>>1, else pat<=pat<<1.
REQ-021 SHALL, on a step in bounce mode with dir=down: if pat[0]=1 then dir<=up and pat<=pat<<1, else pat<=pat>>1.
REQ-022 SHALL produce the bounce sequence 0001,0010,0100,1000,0100,0010,0001,0010,... for N_LED=4, with no repeated end value.
REQ-023 SHALL, on a step in count mode, set pat <= pat+1 modulo 2^N_LED, wrapping 1...1 -> 0...0.
REQ-024 SHALL keep exactly one bit of pat set at all times in run and bounce modes.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: cnt=0, pat=0 (leds all 1), tick=0, dir=up, sync flops=0, mode_q=00.
REQ-026 SHALL, after rst_n deasserts, treat a non-00 mode as a mode change (REQ-014) once it has been synchronised.
REQ-027 SHALL apply reset mid-step or mid-sequence immediately, leaving no partial step.

Verification (N_LED=4, STEP_CYC=4)
REQ-028 SHALL cover: reset, mode=00, en=1 -> leds=1111 until first tick, then toggles 0000/1111 every 4 cycles; tick high 1 cycle per 4.
REQ-029 SHALL cover: mode=01 held from reset -> leds 1110,1101,1011,0111,1110 (pat 0001,0010,0100,1000,0001) at consecutive ticks.
REQ-030 SHALL cover: mode=10 for 8 ticks -> pat 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-031 SHALL cover: mode=11 for 17 ticks -> pat counts 0..15 then wraps to 0; leds=~pat at each step.
REQ-032 SHALL cover: en=0 mid-step with cnt=2 for 20 cycles -> no tick, leds frozen; after en=1, first tick arrives 2 cycles after en_s rises.
REQ-033 SHALL cover: mode change 01->10 timed so reinit coincides with cnt==3 -> no step, pat=0001, cnt restarts at 0; rst_n pulse mid-run -> leds=1111 within same cycle.
